// File: rtl/sseg_frame_decoder.sv
// sseg_frame_decoder: decodes active-low multiplexed 7-seg traffic back into digit codes and a binary value; optional stale timeout under SSEG_DEC_TIMEOUT_EN
module sseg_frame_decoder #(
  parameter int STABLE_CYC = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  ssegs,
  input  logic [3:0]  disp_en,
  output logic [13:0] value,
  output logic [15:0] digits,
  output logic        minus,
  output logic        dashes,
  output logic        dp_valid,
  output logic [1:0]  dp_pos,
  output logic        frame_valid,
  output logic        seg_err,
  output logic        stale
);
  typedef enum logic [1:0] {COLLECT, CONVERT, DONE} state_t;
  localparam logic [7:0] LAST = 8'(STABLE_CYC - 1);
  function automatic logic [4:0] seg_dec(input logic [7:0] p);
    case (p)
      8'h03:   seg_dec = 5'h10;
      8'h9F:   seg_dec = 5'h11;
      8'h25:   seg_dec = 5'h12;
      8'h0D:   seg_dec = 5'h13;
      8'h99:   seg_dec = 5'h14;
      8'h49:   seg_dec = 5'h15;
      8'h41:   seg_dec = 5'h16;
      8'h1F:   seg_dec = 5'h17;
      8'h01:   seg_dec = 5'h18;
      8'h09:   seg_dec = 5'h19;
      8'hFD:   seg_dec = 5'h1A;
      8'hFF:   seg_dec = 5'h1F;
      default: seg_dec = 5'h00;
    endcase
  endfunction
  logic [11:0] in_q;
  logic [7:0]  cnt_q;
  logic        armed_q;
  logic [3:0]  mask_q, mask_d, dp_q, snap_dp_q;
  logic [15:0] codes_q, snap_q, digits_q;
  logic [1:0]  idx_q, pos, sl, dp_pos_q;
  logic [13:0] acc_q, acc_d, value_q;
  logic [3:0]  cur, cur_v;
  logic [4:0]  dec_w;
  logic        changed, pos_ok, fire, cap_ok, bad_cap, go, to_clr, all_dash, dash_bad;
  logic        minus_q, dashes_q, dp_valid_q, fv_q, err_q;
  state_t      state_q;
  assign changed  = {ssegs, disp_en} != in_q;
  assign pos_ok   = in_q[3:0] == 4'hE || in_q[3:0] == 4'hD || in_q[3:0] == 4'hB || in_q[3:0] == 4'h7;
  assign pos      = in_q[3:0] == 4'hD ? 2'd1 : in_q[3:0] == 4'hB ? 2'd2 : in_q[3:0] == 4'h7 ? 2'd3 : 2'd0;
  assign sl       = 2'd3 - pos;
  assign dec_w    = seg_dec({in_q[11:5], 1'b1});
  assign fire     = !changed && pos_ok && armed_q && cnt_q == LAST;
  assign cap_ok   = fire && dec_w[4];
  assign bad_cap  = fire && !dec_w[4];
  assign go       = state_q == COLLECT && mask_q == 4'hF;
  assign mask_d   = ((go || to_clr) ? 4'h0 : mask_q) | (cap_ok ? 4'b0001 << pos : 4'h0);
  assign cur      = snap_q[{~idx_q, 2'b00} +: 4];
  assign cur_v    = (cur == 4'hF || cur == 4'hA) ? 4'd0 : cur;
  assign acc_d    = acc_q * 14'd10 + {10'd0, cur_v};
  assign all_dash = snap_q == 16'hAAAA;
  assign dash_bad = !all_dash && (snap_q[11:8] == 4'hA || snap_q[7:4] == 4'hA || snap_q[3:0] == 4'hA);
  assign value       = value_q;
  assign digits      = digits_q;
  assign minus       = minus_q;
  assign dashes      = dashes_q;
  assign dp_valid    = dp_valid_q;
  assign dp_pos      = dp_pos_q;
  assign frame_valid = fv_q;
  assign seg_err     = err_q;
  // Input stability tracking and one capture per stable dwell into the slot registers
  always_ff @(posedge clk) begin
    if (reset) begin
      in_q    <= '1;
      cnt_q   <= 8'd0;
      armed_q <= 1'b1;
      mask_q  <= 4'h0;
      codes_q <= 16'hFFFF;
      dp_q    <= 4'h0;
    end else begin
      in_q   <= {ssegs, disp_en};
      mask_q <= mask_d;
      if (changed) begin
        cnt_q   <= 8'd0;
        armed_q <= 1'b1;
      end else if (!pos_ok)
        cnt_q <= 8'd0;
      else if (fire)
        armed_q <= 1'b0;
      else if (cnt_q != LAST)
        cnt_q <= cnt_q + 8'd1;
      if (cap_ok) begin
        codes_q[{sl, 2'b00} +: 4] <= dec_w[3:0];
        dp_q[pos]                 <= ~in_q[4];
      end
    end
  end
  // Frame FSM: snapshot a full mask, accumulate leftmost-first, publish or reject the frame
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= COLLECT;
      idx_q      <= 2'd0;
      acc_q      <= 14'd0;
      snap_q     <= 16'hFFFF;
      snap_dp_q  <= 4'h0;
      value_q    <= 14'd0;
      digits_q   <= 16'hFFFF;
      minus_q    <= 1'b0;
      dashes_q   <= 1'b0;
      dp_valid_q <= 1'b0;
      dp_pos_q   <= 2'd0;
      fv_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      fv_q  <= 1'b0;
      err_q <= bad_cap;
      if (go) begin
        snap_q    <= codes_q;
        snap_dp_q <= dp_q;
        acc_q     <= 14'd0;
        idx_q     <= 2'd0;
        state_q   <= CONVERT;
      end else if (state_q == CONVERT) begin
        acc_q <= acc_d;
        idx_q <= idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          state_q <= DONE;
          if (dash_bad)
            err_q <= 1'b1;
          else begin
            fv_q       <= 1'b1;
            value_q    <= all_dash ? 14'd0 : acc_d;
            digits_q   <= snap_q;
            minus_q    <= snap_q[15:12] == 4'hA && !all_dash;
            dashes_q   <= all_dash;
            dp_valid_q <= |snap_dp_q;
            dp_pos_q   <= snap_dp_q[0] ? 2'd0 : snap_dp_q[1] ? 2'd1 : snap_dp_q[2] ? 2'd2 : snap_dp_q[3] ? 2'd3 : 2'd0;
          end
        end
      end else if (state_q == DONE)
        state_q <= COLLECT;
    end
  end
`ifdef SSEG_DEC_TIMEOUT_EN
  logic [15:0] to_q;
  logic        stale_q;
  assign to_clr = !fv_q && to_q == 16'hFFFF;
  assign stale  = stale_q;
  // Frame watchdog: flags stale and drops partial captures after 65535 cycles without a frame
  always_ff @(posedge clk) begin
    if (reset) begin
      to_q    <= 16'd0;
      stale_q <= 1'b0;
    end else if (fv_q) begin
      to_q    <= 16'd0;
      stale_q <= 1'b0;
    end else if (to_clr) begin
      to_q    <= 16'd0;
      stale_q <= 1'b1;
    end else
      to_q <= to_q + 16'd1;
  end
`else
  assign to_clr = 1'b0;
  assign stale  = 1'b0;
`endif
endmodule

// File: tb/tb_sseg_frame_decoder.sv
// tb_sseg_frame_decoder: table-driven frame vectors plus hand sequences for capture, dash and reset corners
module tb_sseg_frame_decoder;
  logic        clk = 1'b0, reset = 1'b1;
  logic [7:0]  ssegs = 8'hFF;
  logic [3:0]  disp_en = 4'hF;
  logic [13:0] value;
  logic [15:0] digits;
  logic        minus, dashes, dp_valid, frame_valid, seg_err, stale;
  logic [1:0]  dp_pos;
  int n_chk = 0, n_fail = 0, fv_cnt = 0, err_cnt = 0, fv_idx = 0;
  typedef struct {
    logic [31:0] pats;
    logic [13:0] value;
    logic [15:0] digits;
    logic        minus, dashes, dpv;
    logic [1:0]  dpp;
    int          fv;
    int          err;
  } vec_t;
  vec_t tbl[7];
  sseg_frame_decoder #(.STABLE_CYC(4)) dut (
    .clk(clk), .reset(reset), .ssegs(ssegs), .disp_en(disp_en), .value(value), .digits(digits),
    .minus(minus), .dashes(dashes), .dp_valid(dp_valid), .dp_pos(dp_pos), .frame_valid(frame_valid),
    .seg_err(seg_err), .stale(stale)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic drive(input logic [3:0] en, input logic [7:0] s, input int cyc);
    ssegs = s;
    disp_en = en;
    fv_idx = 0;
    for (int i = 1; i <= cyc; i++) begin
      @(negedge clk);
      if (frame_valid) begin
        fv_cnt++;
        fv_idx = i;
      end
      if (seg_err) err_cnt++;
    end
  endtask
  task automatic outs(input string t, input logic [13:0] v, input logic [15:0] d, input logic m,
                      input logic ds, input logic dv, input logic [1:0] dp);
    chk({t, ".value"}, 32'(value), 32'(v));
    chk({t, ".digits"}, 32'(digits), 32'(d));
    chk({t, ".minus"}, 32'(minus), 32'(m));
    chk({t, ".dashes"}, 32'(dashes), 32'(ds));
    chk({t, ".dp_valid"}, 32'(dp_valid), 32'(dv));
    chk({t, ".dp_pos"}, 32'(dp_pos), 32'(dp));
    chk({t, ".stale"}, 32'(stale), 32'(0));
  endtask
  initial begin
    tbl[0] = '{32'h9F250D99, 14'd1234, 16'h1234, 1'b0, 1'b0, 1'b0, 2'd0, 1, 0};
    tbl[1] = '{32'hFDFF9925, 14'd42,   16'hAF42, 1'b1, 1'b0, 1'b0, 2'd0, 1, 0};
    tbl[2] = '{32'hFDFDFDFD, 14'd0,    16'hAAAA, 1'b0, 1'b1, 1'b0, 2'd0, 1, 0};
    tbl[3] = '{32'h03030C03, 14'd30,   16'h0030, 1'b0, 1'b0, 1'b1, 2'd2, 1, 0};
    tbl[4] = '{32'h03240398, 14'd204,  16'h0204, 1'b0, 1'b0, 1'b1, 2'd1, 1, 0};
    tbl[5] = '{32'h03FD0303, 14'd204,  16'h0204, 1'b0, 1'b0, 1'b1, 2'd1, 0, 1};
    tbl[6] = '{32'h09550141, 14'd204,  16'h0204, 1'b0, 1'b0, 1'b1, 2'd1, 0, 1};
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst.frame_valid", 32'(frame_valid), 32'(0));
    chk("rst.seg_err", 32'(seg_err), 32'(0));
    outs("rst", 14'd0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 2'd0);
    for (int r = 0; r < 7; r++) begin
      fv_cnt = 0;
      err_cnt = 0;
      for (int j = 0; j < 4; j++)
        drive(~(4'b0001 << j), tbl[r].pats[31 - 8 * j -: 8], j == 3 ? 14 : 8);
      chk($sformatf("row%0d.fv_count", r), 32'(fv_cnt), 32'(tbl[r].fv));
      chk($sformatf("row%0d.err_count", r), 32'(err_cnt), 32'(tbl[r].err));
      if (tbl[r].fv == 1) chk($sformatf("row%0d.fv_latency", r), 32'(fv_idx), 32'(10));
      outs($sformatf("row%0d", r), tbl[r].value, tbl[r].digits, tbl[r].minus, tbl[r].dashes, tbl[r].dpv, tbl[r].dpp);
    end
    fv_cnt = 0;
    err_cnt = 0;
    drive(4'b1101, 8'h9F, 2);
    drive(4'b1111, 8'hFF, 8);
    chk("short_dwell.fv_count", 32'(fv_cnt), 32'(0));
    chk("short_dwell.err_count", 32'(err_cnt), 32'(0));
    outs("short_dwell", 14'd204, 16'h0204, 1'b0, 1'b0, 1'b1, 2'd1);
    drive(4'b1101, 8'h0D, 14);
    chk("resend.fv_count", 32'(fv_cnt), 32'(1));
    chk("resend.fv_latency", 32'(fv_idx), 32'(10));
    chk("resend.err_count", 32'(err_cnt), 32'(0));
    outs("resend", 14'd9386, 16'h9386, 1'b0, 1'b0, 1'b0, 2'd0);
    fv_cnt = 0;
    err_cnt = 0;
    drive(4'b1110, 8'h9F, 8);
    drive(4'b1101, 8'h25, 8);
    drive(4'b1011, 8'h0D, 8);
    drive(4'b0111, 8'h99, 7);
    reset = 1'b1;
    drive(4'b0111, 8'h99, 2);
    reset = 1'b0;
    drive(4'b0111, 8'h99, 12);
    chk("abort.fv_count", 32'(fv_cnt), 32'(0));
    chk("abort.err_count", 32'(err_cnt), 32'(0));
    outs("abort", 14'd0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 2'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
